// File: rtl/espi_slave_cmd_engine.sv
// eSPI slave command engine: consumes command bytes from the serial PHY, checks
// the command CRC-8, executes GET_STATUS / GET_CONFIGURATION / SET_CONFIGURATION /
// RESET against a small config register file and streams the response bytes back.
//
// Ports:
//   sclk, reset_n          clock (posedge) and async active-low reset (clears config too)
//   cs_n                   high = async frame clear (FSM, counters, outputs; config kept)
//   rx_valid, rx_data      one received command byte per rx_valid pulse
//   tx_valid, tx_data      response byte offered to the PHY, held until tx_ready
//   tx_ready               PHY accepts tx_data (transfer = tx_valid && tx_ready)
//   status_in              live slave status, captured when the command CRC checks
//   gen_cfg, ch0_cfg,
//   ch1_cfg                config registers
//   crc_err, cmd_err,
//   frame_done             single-cycle event pulses
module espi_slave_cmd_engine #(
  parameter logic [31:0] DEVICE_ID   = 32'h0000_0001,
  parameter logic [31:0] GEN_CFG_RST = 32'h0000_0000,
  parameter logic [31:0] CH_CFG_RST  = 32'h0000_0001
) (
  input  logic        sclk,
  input  logic        reset_n,
  input  logic        cs_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic [15:0] status_in,
  output logic [31:0] gen_cfg,
  output logic [31:0] ch0_cfg,
  output logic [31:0] ch1_cfg,
  output logic        crc_err,
  output logic        cmd_err,
  output logic        frame_done
);

  localparam logic [7:0] OP_GET_STATUS = 8'h25;
  localparam logic [7:0] OP_GET_CONFIG = 8'h21;
  localparam logic [7:0] OP_SET_CONFIG = 8'h22;
  localparam logic [7:0] OP_RESET      = 8'hFF;
  localparam logic [7:0] RESP_ACCEPT   = 8'h08;

  typedef enum logic [2:0] {S_OPC, S_HDR, S_CRC, S_RESP, S_DONE} state_t;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++)
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  state_t      state;
  logic [7:0]  opcode;
  logic [2:0]  hdr_cnt;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [7:0]  cmd_crc;
  logic [47:0] resp_sh;
  logic [7:0]  resp_crc;
  logic [2:0]  resp_idx;
  logic [2:0]  resp_last;

  logic        frame_rst_n;
  logic        cmd_commit;
  logic        wr_en;
  logic        rst_cmd;
  logic        tx_fire;
  logic [7:0]  resp_crc_nxt;
  logic [31:0] rd_data;

  // Either reset source clears the frame; only reset_n touches the config file.
  assign frame_rst_n  = reset_n & ~cs_n;
  assign cmd_commit   = !cs_n && state == S_CRC && rx_valid && rx_data == cmd_crc;
  assign wr_en        = cmd_commit && opcode == OP_SET_CONFIG;
  assign rst_cmd      = !cs_n && state == S_OPC && rx_valid && rx_data == OP_RESET;
  assign tx_fire      = tx_valid && tx_ready;
  assign resp_crc_nxt = crc8_byte(resp_crc, tx_data);

  always_comb begin
    rd_data = '0;
    case (addr)
      16'h0004: rd_data = DEVICE_ID;
      16'h0008: rd_data = gen_cfg;
      16'h0010: rd_data = ch0_cfg;
      16'h0020: rd_data = ch1_cfg;
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      gen_cfg <= GEN_CFG_RST;
      ch0_cfg <= CH_CFG_RST;
      ch1_cfg <= CH_CFG_RST;
    end else if (rst_cmd) begin
      gen_cfg <= GEN_CFG_RST;
      ch0_cfg <= CH_CFG_RST;
      ch1_cfg <= CH_CFG_RST;
    end else if (wr_en) begin
      case (addr)
        16'h0008: gen_cfg <= wdata;
        16'h0010: ch0_cfg <= wdata;
        16'h0020: ch1_cfg <= wdata;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      state      <= S_OPC;
      opcode     <= '0;
      hdr_cnt    <= '0;
      addr       <= '0;
      wdata      <= '0;
      cmd_crc    <= '0;
      resp_sh    <= '0;
      resp_crc   <= '0;
      resp_idx   <= '0;
      resp_last  <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      crc_err    <= 1'b0;
      cmd_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      crc_err    <= 1'b0;
      cmd_err    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_OPC: if (rx_valid) begin
          opcode  <= rx_data;
          cmd_crc <= crc8_byte('0, rx_data);
          case (rx_data)
            OP_GET_STATUS: state <= S_CRC;
            OP_GET_CONFIG: begin hdr_cnt <= 3'd2; state <= S_HDR; end
            OP_SET_CONFIG: begin hdr_cnt <= 3'd6; state <= S_HDR; end
            OP_RESET:      state <= S_DONE;
            default:       begin cmd_err <= 1'b1; state <= S_DONE; end
          endcase
        end
        S_HDR: if (rx_valid) begin
          cmd_crc <= crc8_byte(cmd_crc, rx_data);
          // SET sends two address bytes (MSB first) then four data bytes (LSB first).
          if (opcode == OP_GET_CONFIG || hdr_cnt > 3'd4)
            addr <= {addr[7:0], rx_data};
          else
            wdata <= {rx_data, wdata[31:8]};
          hdr_cnt <= hdr_cnt - 3'd1;
          if (hdr_cnt == 3'd1) state <= S_CRC;
        end
        S_CRC: if (rx_valid) begin
          if (rx_data == cmd_crc) begin
            tx_valid <= 1'b1;
            tx_data  <= RESP_ACCEPT;
            resp_crc <= '0;
            resp_idx <= '0;
            // Payload bytes queued LSB first; the CRC byte is appended at the end.
            if (opcode == OP_GET_CONFIG) begin
              resp_sh   <= {status_in, rd_data};
              resp_last <= 3'd7;
            end else begin
              resp_sh   <= {32'h0, status_in};
              resp_last <= 3'd3;
            end
            state <= S_RESP;
          end else begin
            crc_err <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_RESP: if (tx_fire) begin
          resp_crc <= resp_crc_nxt;
          if (resp_idx == resp_last) begin
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            resp_idx <= resp_idx + 3'd1;
            if (resp_idx + 3'd1 == resp_last) begin
              tx_data <= resp_crc_nxt;
            end else begin
              tx_data <= resp_sh[7:0];
              resp_sh <= {8'h00, resp_sh[47:8]};
            end
          end
        end
        S_DONE:  ;
        default: state <= S_OPC;
      endcase
    end
  end

endmodule
